// File: rtl/remote_cmd_pkg.sv
// Shared constants and FSM state type for the remote command arbiter.
package remote_cmd_pkg;

    localparam logic [7:0] SET_PITCH    = 8'h02;
    localparam logic [7:0] SET_ROLL     = 8'h03;
    localparam logic [7:0] SET_YAW      = 8'h04;
    localparam logic [7:0] SET_THRST    = 8'h05;
    localparam logic [7:0] CALIBRATE    = 8'h06;
    localparam logic [7:0] E_LAND       = 8'h07;
    localparam logic [7:0] MOTORS_OFF   = 8'h08;

    localparam logic [7:0] RESP_POS_ACK = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_SENT,
        WAIT_RESP,
        CLR,
        DONE
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the requester granted last gets lowest priority.
module rr_arb2
    import remote_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    // Index of the requester that wins a tie; 0 after reset.
    logic prio_reg;

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = (req == 2'b11) ? prio_reg : req[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_reg <= 1'b0;
        end else if (take && gnt_valid) begin
            prio_reg <= ~gnt_idx;
        end
    end

endmodule

// File: rtl/remote_cmd_arb.sv
// Arbitrates two command requesters onto one RemoteComm link with timeout and retry.
// Optional macro E_LAND_PRIO_EN: a pending E_LAND command overrides round-robin order.
module remote_cmd_arb
    import remote_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MAX_RETRY      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [7:0]  cmd0,
    input  logic [7:0]  cmd1,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    output logic        done0,
    output logic        done1,
    output logic        ok0,
    output logic        ok1,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        send_cmd,
    input  logic        cmd_sent,
    input  logic        resp_rdy,
    input  logic [7:0]  resp,
    output logic        clr_resp_rdy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

    arb_state_e      state_reg, state_next;
    logic [TW-1:0]   timer_reg, timer_next;
    logic [RW-1:0]   retry_reg, retry_next;
    logic [7:0]      resp_reg,  resp_next;
    logic [7:0]      cmd_reg,   cmd_next;
    logic [15:0]     data_reg,  data_next;
    logic            gnt_reg,   gnt_next;

    logic [1:0]      req_vec;
    logic [1:0]      arb_req;
    logic            gnt_valid;
    logic            gnt_idx;

    assign req_vec = {req1, req0};

`ifdef E_LAND_PRIO_EN
    logic [1:0] urgent;
    assign urgent  = req_vec & {(cmd1 == E_LAND), (cmd0 == E_LAND)};
    // Restricting the arbiter to urgent requesters keeps round-robin when both are E_LAND.
    assign arb_req = (|urgent) ? urgent : req_vec;
`else
    assign arb_req = req_vec;
`endif

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (arb_req),
        .take      (state_reg == IDLE),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        state_next   = state_reg;
        timer_next   = timer_reg;
        retry_next   = retry_reg;
        resp_next    = resp_reg;
        cmd_next     = cmd_reg;
        data_next    = data_reg;
        gnt_next     = gnt_reg;

        send_cmd     = (state_reg == SEND);
        clr_resp_rdy = (state_reg == CLR);
        done0        = (state_reg == DONE) && !gnt_reg;
        done1        = (state_reg == DONE) &&  gnt_reg;
        ok0          = done0 && (resp_reg == RESP_POS_ACK);
        ok1          = done1 && (resp_reg == RESP_POS_ACK);

        case (state_reg)
            IDLE: begin
                if (gnt_valid) begin
                    gnt_next   = gnt_idx;
                    cmd_next   = gnt_idx ? cmd1  : cmd0;
                    data_next  = gnt_idx ? data1 : data0;
                    state_next = SEND;
                end
            end
            SEND: begin
                timer_next = '0;
                state_next = WAIT_SENT;
            end
            WAIT_SENT: begin
                timer_next = timer_reg + 1'b1;
                if (cmd_sent) begin
                    state_next = WAIT_RESP;
                end else if (timer_reg == TIMER_LAST) begin
                    // A timed-out attempt is treated as a non-ACK so CLR decides the retry.
                    resp_next  = 8'h00;
                    state_next = CLR;
                end
            end
            WAIT_RESP: begin
                timer_next = timer_reg + 1'b1;
                if (resp_rdy) begin
                    resp_next  = resp;
                    state_next = CLR;
                end else if (timer_reg == TIMER_LAST) begin
                    resp_next  = 8'h00;
                    state_next = CLR;
                end
            end
            CLR: begin
                if (resp_reg == RESP_POS_ACK) begin
                    state_next = DONE;
                end else if (retry_reg < RETRY_MAX) begin
                    retry_next = retry_reg + 1'b1;
                    state_next = SEND;
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                retry_next = '0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        cmd  = cmd_reg;
        data = data_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            retry_reg <= '0;
            resp_reg  <= '0;
            cmd_reg   <= '0;
            data_reg  <= '0;
            gnt_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            retry_reg <= retry_next;
            resp_reg  <= resp_next;
            cmd_reg   <= cmd_next;
            data_reg  <= data_next;
            gnt_reg   <= gnt_next;
        end
    end

endmodule

// File: tb/tb_remote_cmd_arb.sv
// Directed bench for remote_cmd_arb with a transaction-level outcome model and RemoteComm responder.
module tb_remote_cmd_arb;
    import remote_cmd_pkg::*;

    localparam int TO     = 100;
    localparam int MR     = 2;
    localparam int SILENT = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req0, req1;
    logic [7:0]  cmd0, cmd1;
    logic [15:0] data0, data1;
    logic        done0, done1, ok0, ok1;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        send_cmd, cmd_sent, resp_rdy, clr_resp_rdy;
    logic [7:0]  resp;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int resp_q[$];
    int exp_id_q[$];
    int exp_ok_q[$];
    int exp_n_q[$];
    int exp_clr_q[$];
    int send_cyc_q[$];
    bit model_last;
    int mon_sends;
    int mon_clrs;

    remote_cmd_arb #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0         (req0),
        .req1         (req1),
        .cmd0         (cmd0),
        .cmd1         (cmd1),
        .data0        (data0),
        .data1        (data1),
        .done0        (done0),
        .done1        (done1),
        .ok0          (ok0),
        .ok1          (ok1),
        .cmd          (cmd),
        .data         (data),
        .send_cmd     (send_cmd),
        .cmd_sent     (cmd_sent),
        .resp_rdy     (resp_rdy),
        .resp         (resp),
        .clr_resp_rdy (clr_resp_rdy)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Grant rule: E_LAND (when enabled) first, otherwise whoever was not granted last.
    function automatic int rr_pick(input bit r0, input bit r1);
`ifdef E_LAND_PRIO_EN
        bit u0 = r0 && (cmd0 == E_LAND);
        bit u1 = r1 && (cmd1 == E_LAND);
        if (u0 && !u1) return 0;
        if (u1 && !u0) return 1;
`endif
        if (r0 && r1) return model_last ? 0 : 1;
        return r1 ? 1 : 0;
    endfunction

    // Outcome of one transaction from its scripted responses: first ACK wins, else MR+1 attempts fail.
    task automatic plan(input int id, input int ra, input int rb, input int rc,
                        output int n, output int ok);
        int r[3];
        bit any_silent;
        r = '{ra, rb, rc};
        n = MR + 1;
        ok = 0;
        any_silent = 0;
        for (int i = 0; i < MR + 1; i++) begin
            resp_q.push_back(r[i]);
            if (r[i] == SILENT) any_silent = 1;
            if (r[i] == int'(RESP_POS_ACK)) begin
                n = i + 1;
                ok = 1;
                break;
            end
        end
        exp_id_q.push_back(id);
        exp_ok_q.push_back(ok);
        exp_n_q.push_back(n);
        exp_clr_q.push_back(any_silent ? -1 : n);
        model_last = id[0];
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                mon_sends = 0;
                mon_clrs = 0;
            end else begin
                if (send_cmd) begin
                    if (exp_id_q.size() == 0) begin
                        flag("unexpected_send");
                    end else begin
                        chk("send_cmd_byte", cmd, exp_id_q[0] != 0 ? cmd1 : cmd0);
                        chk("send_payload", data, exp_id_q[0] != 0 ? data1 : data0);
                    end
                    mon_sends++;
                    send_cyc_q.push_back(cyc);
                end
                if (clr_resp_rdy) mon_clrs++;
                if ((ok0 && !done0) || (ok1 && !done1)) flag("ok_without_done");
                if (done0 || done1) begin
                    chk("done_onehot", int'(done0 & done1), 0);
                    if (exp_id_q.size() == 0) begin
                        flag("unexpected_done");
                    end else begin
                        chk("done_requester", int'(done1), exp_id_q[0]);
                        chk("ok_value", int'(done1 ? ok1 : ok0), exp_ok_q[0]);
                        chk("send_count", mon_sends, exp_n_q[0]);
                        if (exp_clr_q[0] >= 0) chk("clr_count", mon_clrs, exp_clr_q[0]);
                        void'(exp_id_q.pop_front());
                        void'(exp_ok_q.pop_front());
                        void'(exp_n_q.pop_front());
                        void'(exp_clr_q.pop_front());
                    end
                    mon_sends = 0;
                    mon_clrs = 0;
                end
            end
        end
    endtask

    // RemoteComm stand-in: cmd_sent 2 cycles after the strobe, response 3 cycles later.
    task automatic responder();
        int r;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && send_cmd) begin
                r = (resp_q.size() != 0) ? resp_q.pop_front() : SILENT;
                repeat (2) @(posedge clk);
                #1 cmd_sent = 1'b1;
                @(posedge clk);
                #1 cmd_sent = 1'b0;
                if (r != SILENT) begin
                    repeat (3) @(posedge clk);
                    #1;
                    resp = r[7:0];
                    resp_rdy = 1'b1;
                    for (int k = 0; k < 200 && !clr_resp_rdy; k++) begin
                        @(posedge clk);
                        #1;
                    end
                    resp_rdy = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_dones(input int n, output int last_id);
        int seen = 0;
        last_id = -1;
        for (int k = 0; k < 3000 && seen < n; k++) begin
            @(posedge clk);
            #2;
            if (done0 || done1) begin
                seen++;
                last_id = done1 ? 1 : 0;
            end
        end
        if (seen < n) flag("wait_done_expired");
    endtask

    task automatic wait_send();
        bit seen = 0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(posedge clk);
            #2;
            if (send_cmd) seen = 1;
        end
        if (!seen) flag("wait_send_expired");
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_cmd"}, cmd, 0);
        chk({tag, "_data"}, data, 0);
        chk({tag, "_strobes"}, {send_cmd, clr_resp_rdy, done0, done1, ok0, ok1}, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        resp_q.delete();
        exp_id_q.delete();
        exp_ok_q.delete();
        exp_n_q.delete();
        exp_clr_q.delete();
        model_last = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int id, n, ok, lid, base;
        int order[3];
        req0 = 0; req1 = 0; cmd0 = 0; cmd1 = 0; data0 = 0; data1 = 0;
        cmd_sent = 0; resp_rdy = 0; resp = 0;
        mon_sends = 0; mon_clrs = 0; model_last = 1'b1;
        fork
            monitor();
            responder();
        join_none

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 check_idle_outputs("reset");
        @(negedge clk) rst_n = 1'b1;

        // Single ACKed command from requester 0.
        cmd0 = SET_THRST; data0 = 16'h0666;
        id = rr_pick(1, 0);
        chk("model_pick_single", id, 0);
        plan(id, int'(RESP_POS_ACK), SILENT, SILENT, n, ok);
        chk("model_n_ack", n, 1);
        chk("model_ok_ack", ok, 1);
        @(posedge clk); #2 req0 = 1;
        wait_dones(1, lid);
        req0 = 0;
        chk("single_done_id", lid, 0);
        repeat (3) @(posedge clk);

        // Both requesters held: fresh pointer alternates 0,1,0.
        do_reset();
        cmd0 = SET_PITCH; data0 = 16'h1111;
        cmd1 = SET_YAW;   data1 = 16'h2222;
        for (int g = 0; g < 3; g++) begin
            order[g] = rr_pick(1, 1);
            plan(order[g], int'(RESP_POS_ACK), SILENT, SILENT, n, ok);
        end
        chk("model_rr0", order[0], 0);
        chk("model_rr1", order[1], 1);
        chk("model_rr2", order[2], 0);
        @(posedge clk); #2 req0 = 1; req1 = 1;
        wait_dones(3, lid);
        req0 = 0; req1 = 0;
        repeat (3) @(posedge clk);

        // Three NAKs exhaust the retries.
        cmd1 = SET_PITCH; data1 = 16'h1234;
        id = rr_pick(0, 1);
        plan(id, 0, 0, 0, n, ok);
        chk("model_n_nak", n, 3);
        chk("model_ok_nak", ok, 0);
        @(posedge clk); #2 req1 = 1;
        wait_dones(1, lid);
        req1 = 0;
        repeat (3) @(posedge clk);

        // No response at all: three attempts 102 cycles apart.
        cmd0 = CALIBRATE; data0 = 16'hBEEF;
        plan(rr_pick(1, 0), SILENT, SILENT, SILENT, n, ok);
        chk("model_n_timeout", n, 3);
        base = send_cyc_q.size();
        @(posedge clk); #2 req0 = 1;
        wait_dones(1, lid);
        req0 = 0;
        if (send_cyc_q.size() >= base + 3) begin
            chk("timeout_gap1", send_cyc_q[base+1] - send_cyc_q[base], 102);
            chk("timeout_gap2", send_cyc_q[base+2] - send_cyc_q[base+1], 102);
        end else begin
            flag("timeout_send_missing");
        end
        repeat (3) @(posedge clk);

        // NAK then ACK, and timeout then ACK.
        plan(rr_pick(0, 1), 0, int'(RESP_POS_ACK), SILENT, n, ok);
        chk("model_n_nak_ack", n, 2);
        chk("model_ok_nak_ack", ok, 1);
        @(posedge clk); #2 req1 = 1;
        wait_dones(1, lid);
        req1 = 0;
        repeat (3) @(posedge clk);
        plan(rr_pick(1, 0), SILENT, int'(RESP_POS_ACK), SILENT, n, ok);
        @(posedge clk); #2 req0 = 1;
        wait_dones(1, lid);
        req0 = 0;
        repeat (3) @(posedge clk);

        // Requester drops req mid-transaction; done still arrives.
        cmd1 = SET_ROLL; data1 = 16'h5A5A;
        plan(rr_pick(0, 1), int'(RESP_POS_ACK), SILENT, SILENT, n, ok);
        @(posedge clk); #2 req1 = 1;
        wait_send();
        req1 = 0;
        wait_dones(1, lid);
        chk("dropped_req_done_id", lid, 1);
        repeat (3) @(posedge clk);

        // Asynchronous reset while waiting for the response, then a clean transaction.
        cmd1 = MOTORS_OFF; data1 = 16'hCAFE;
        plan(rr_pick(0, 1), SILENT, SILENT, SILENT, n, ok);
        @(posedge clk); #2 req1 = 1;
        wait_send();
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_idle_outputs("async_reset");
        req1 = 0;
        resp_q.delete();
        exp_id_q.delete();
        exp_ok_q.delete();
        exp_n_q.delete();
        exp_clr_q.delete();
        model_last = 1'b1;
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        cmd0 = SET_ROLL; data0 = 16'h0042;
        id = rr_pick(1, 0);
        plan(id, int'(RESP_POS_ACK), SILENT, SILENT, n, ok);
        @(posedge clk); #2 req0 = 1;
        wait_dones(1, lid);
        req0 = 0;
        chk("post_reset_done_id", lid, 0);
        repeat (3) @(posedge clk);

        // E_LAND against SET_ROLL right after a requester-1 grant.
        cmd1 = SET_YAW; data1 = 16'h7777;
        plan(rr_pick(0, 1), int'(RESP_POS_ACK), SILENT, SILENT, n, ok);
        @(posedge clk); #2 req1 = 1;
        wait_dones(1, lid);
        req1 = 0;
        repeat (3) @(posedge clk);
        cmd0 = SET_ROLL; data0 = 16'h0303;
        cmd1 = E_LAND;   data1 = 16'h0707;
        id = rr_pick(1, 1);
`ifdef E_LAND_PRIO_EN
        chk("model_eland_first", id, 1);
`else
        chk("model_rr_first", id, 0);
`endif
        plan(id, int'(RESP_POS_ACK), SILENT, SILENT, n, ok);
        plan(1 - id, int'(RESP_POS_ACK), SILENT, SILENT, n, ok);
        @(posedge clk); #2 req0 = 1; req1 = 1;
        wait_dones(1, lid);
        chk("contest_first_id", lid, id);
        if (id != 0) req1 = 0; else req0 = 0;
        wait_dones(1, lid);
        req0 = 0; req1 = 0;
        repeat (5) @(posedge clk);

        chk("leftover_expectations", exp_id_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
